// File: rtl/wb_sdram_responder.sv
// Wishbone B3 slave backed by a local word memory; mimics the SDRAM controller's
// bus/init behaviour (init delay, first-beat latency, byte selects, CTI bursts).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_INIT  | counting INIT_CYCLES after reset release, bus ignored
// S_IDLE  | ready, waiting for cyc&stb
// S_WAIT  | first-beat latency down-count
// S_ACK   | single/first beat acked, decide classic end or burst
// S_BURST | incrementing burst, one ack per cycle while cyc&stb
module wb_sdram_responder #(
  parameter int dw          = 32,
  parameter int APP_AW      = 26,
  parameter int MEM_AW      = 10,
  parameter int ACK_LAT     = 2,
  parameter int INIT_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [APP_AW-1:0] wb_addr_i,
  input  logic [dw-1:0]     wb_dat_i,
  input  logic [dw/8-1:0]   wb_sel_i,
  input  logic [2:0]        wb_cti_i,
  output logic              wb_ack_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic              sdr_init_done
);

  localparam int NB = dw / 8;
  localparam int B  = $clog2(NB);
  localparam int IW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  state_t            state;
  logic [IW-1:0]     init_cnt;
  logic [3:0]        wait_cnt;
  logic [MEM_AW-1:0] idx;
  logic              we_q;
  logic [dw-1:0]     mem [2**MEM_AW];

  logic              req;
  logic              beat_done;
  logic [MEM_AW-1:0] addr_idx;
  logic [MEM_AW-1:0] idx_next;
  logic              addr_unused;

  assign req         = wb_cyc_i & wb_stb_i;
  assign addr_idx    = wb_addr_i[MEM_AW+B-1:B];
  assign idx_next    = idx + MEM_AW'(1);
  assign addr_unused = ^{wb_addr_i[APP_AW-1:MEM_AW+B], wb_addr_i[B-1:0]};

  // An acked beat completes unless the master merely paused stb; a cyc drop
  // in the ack cycle still commits the write.
  assign beat_done = wb_ack_o & (wb_stb_i | ~wb_cyc_i);

  always_ff @(posedge sys_clk) begin
    if (beat_done && wb_we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wb_sel_i[i]) mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      wait_cnt      <= '0;
      idx           <= '0;
      we_q          <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= '0;
      sdr_init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            sdr_init_done <= 1'b1;
            state         <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req) begin
            idx      <= addr_idx;
            we_q     <= wb_we_i;
            wait_cnt <= 4'(ACK_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            wb_ack_o <= 1'b1;
            if (!we_q) wb_dat_o <= mem[idx];
            state    <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACK, S_BURST: begin
          if (!wb_cyc_i) begin
            wb_ack_o <= 1'b0;
            state    <= S_IDLE;
          end else if (wb_ack_o) begin
            if (!wb_stb_i) begin
              wb_ack_o <= 1'b0;
              if (state == S_ACK) state <= S_IDLE;
            end else if (wb_cti_i == 3'b010) begin
              // Next beat's direction is not yet visible, so its read data is always prefetched.
              idx      <= idx_next;
              wb_dat_o <= mem[idx_next];
              state    <= S_BURST;
            end else begin
              wb_ack_o <= 1'b0;
              state    <= S_IDLE;
            end
          end else if (wb_stb_i) begin
            wb_ack_o <= 1'b1;
            if (!wb_we_i) wb_dat_o <= mem[idx];
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_responder.sv
// Directed bench for wb_sdram_responder: init timing, latency, byte lanes,
// bursts with wrap/aliasing, aborted cycles and asynchronous reset.
module tb_wb_sdram_responder;

  logic        sys_clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [25:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        init_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] bdat_w [4];
  logic [31:0] bdat_r [4];

  always #5 sys_clk = ~sys_clk;

  wb_sdram_responder #(
    .dw(32), .APP_AW(26), .MEM_AW(10), .ACK_LAT(2), .INIT_CYCLES(16)
  ) dut (
    .sys_clk(sys_clk), .wb_rst_i(wb_rst_i),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_cti_i(cti),
    .wb_ack_o(ack), .wb_dat_o(rdat), .sdr_init_done(init_done)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Classic cycle; lat = edges from request until ack seen (0 = no ack).
  task automatic wb_single(input logic w, input logic [25:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic [31:0] q,
                           output logic ack_after);
    lat = 0; q = '0; ack_after = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s; cti = 3'b000;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack) begin lat = n; q = rdat; break; end
    end
    if (lat != 0) begin tick(); ack_after = ack; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  // Incrementing burst of n beats; data from bdat_w, read data into bdat_r.
  task automatic wb_burst(input logic w, input logic [25:0] a, input int n,
                          output int acks, output int first, output int last,
                          output logic ack_end);
    int i;
    logic ack_prev;
    acks = 0; first = 0; last = 0; i = 0;
    for (int k = 0; k < 4; k++) bdat_r[k] = '0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = bdat_w[0]; sel = 4'hF;
    cti = (n == 1) ? 3'b111 : 3'b010;
    for (int e = 1; e <= 40 && i < n; e++) begin
      ack_prev = ack;
      tick();
      if (ack_prev) begin
        i++;
        if (i < n) begin
          addr = addr + 26'd4; wdat = bdat_w[i];
          cti = (i == n - 1) ? 3'b111 : 3'b010;
        end else begin
          cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        end
      end
      if (ack && i < n) begin
        acks++;
        if (first == 0) first = e;
        last = e;
        bdat_r[i] = rdat;
      end
    end
    ack_end = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic early, d15, d16;
    int first;
    early = 1'b0; d15 = 1'b1; d16 = 1'b0; first = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h0; sel = 4'hF; cti = 3'b000;
    tick(); tick(); tick();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b expected 0", ack); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    tests++; if (rdat !== 32'h0) begin fails++; $display("FAIL rst_dat: got %h expected 00000000", rdat); end
    wb_rst_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 16 && ack) early = 1'b1;
      if (k == 15) d15 = init_done;
      if (k == 16) d16 = init_done;
      if (ack) begin first = k; break; end
    end
    tests++; if (d15 !== 1'b0) begin fails++; $display("FAIL init_edge15: got %b expected 0", d15); end
    tests++; if (d16 !== 1'b1) begin fails++; $display("FAIL init_edge16: got %b expected 1", d16); end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL ack_during_init: got %b expected 0", early); end
    tests++; if (first != 20) begin fails++; $display("FAIL first_ack_edge: got %0d expected 20", first); end
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] q; logic aa;
    wb_single(1'b1, 26'h40, 32'hDEADBEEF, 4'hF, lat, q, aa);
    tests++; if (lat != 4) begin fails++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    tests++; if (aa !== 1'b0) begin fails++; $display("FAIL wr_ack_width: got %b expected 0", aa); end
    wb_single(1'b0, 26'h40, 32'h0, 4'hF, lat, q, aa);
    tests++; if (lat != 4) begin fails++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    tests++; if (q !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", q); end
  endtask

  task automatic test_byte_sel();
    int lat; logic [31:0] q; logic aa;
    wb_single(1'b1, 26'h40, 32'h11223344, 4'b0101, lat, q, aa);
    wb_single(1'b0, 26'h40, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'hDE22BE44) begin fails++; $display("FAIL byte_sel: got %h expected de22be44", q); end
  endtask

  task automatic test_burst_read();
    int lat, acks, first, last; logic [31:0] q; logic aa, ae;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA0000000; exp_d[1] = 32'hA0000001;
    exp_d[2] = 32'hA0000002; exp_d[3] = 32'hA0000003;
    for (int k = 0; k < 4; k++)
      wb_single(1'b1, 26'h100 + 26'(4 * k), exp_d[k], 4'hF, lat, q, aa);
    wb_burst(1'b0, 26'h100, 4, acks, first, last, ae);
    tests++; if (acks != 4) begin fails++; $display("FAIL burst_acks: got %0d expected 4", acks); end
    tests++; if (first != 4 || last != 7) begin fails++; $display("FAIL burst_b2b: got first %0d last %0d expected 4 7", first, last); end
    tests++; if (ae !== 1'b0) begin fails++; $display("FAIL burst_ack_end: got %b expected 0", ae); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bdat_r[k] !== exp_d[k]) begin fails++; $display("FAIL burst_data%0d: got %h expected %h", k, bdat_r[k], exp_d[k]); end
    end
  endtask

  task automatic test_wrap_alias();
    int lat, acks, first, last; logic [31:0] q; logic aa, ae;
    bdat_w[0] = 32'h55555555; bdat_w[1] = 32'h66666666;
    bdat_w[2] = 32'h0; bdat_w[3] = 32'h0;
    wb_burst(1'b1, 26'hFFC, 2, acks, first, last, ae);
    tests++; if (acks != 2) begin fails++; $display("FAIL wrap_acks: got %0d expected 2", acks); end
    wb_single(1'b0, 26'hFFC, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'h55555555) begin fails++; $display("FAIL wrap_idx3ff: got %h expected 55555555", q); end
    wb_single(1'b0, 26'h0, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'h66666666) begin fails++; $display("FAIL wrap_idx0: got %h expected 66666666", q); end
    wb_single(1'b0, 26'h1000, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'h66666666) begin fails++; $display("FAIL alias_1000: got %h expected 66666666", q); end
  endtask

  task automatic test_abort_and_reset();
    int lat; logic [31:0] q; logic aa, seen, got;
    seen = 1'b0; got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 26'h40; wdat = 32'h12345678; sel = 4'hF; cti = 3'b000;
    tick(); tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); if (ack) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_ack: got %b expected 0", seen); end
    wb_single(1'b0, 26'h40, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'hDE22BE44) begin fails++; $display("FAIL abort_mem: got %h expected de22be44", q); end

    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h100; cti = 3'b010;
    for (int k = 0; k < 40; k++) begin tick(); if (ack) begin got = 1'b1; break; end end
    tests++; if (got !== 1'b1) begin fails++; $display("FAIL rst_burst_start: got %b expected 1", got); end
    wb_rst_i = 1'b1;
    #1;
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL async_rst_ack: got %b expected 0", ack); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL async_rst_init: got %b expected 0", init_done); end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick();
    wb_rst_i = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL reinit_done: got %b expected 1", init_done); end
    wb_single(1'b0, 26'h100, 32'h0, 4'hF, lat, q, aa);
    tests++; if (q !== 32'hA0000000) begin fails++; $display("FAIL mem_retained: got %h expected a0000000", q); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_sel();
    test_burst_read();
    test_wrap_alias();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
